issue_hazard_ctrl: RTL and testbench
====================================

ISSUE_HAZARD_CTRL -- requirements
Module: issue_hazard_ctrl

Interface
REQ-001 clock  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 id_valid  input  3  per-way valid of incoming decoded group; way 0 oldest.
REQ-004 id_packet  input  ID_EX_PACKET[2:0]  incoming decoded group.
REQ-005 rollback  input  2  youngest-way hold count from hazard detection, evaluated on the cand_* group in the same cycle.
REQ-006 squash  input  1  branch-mispredict flush.
REQ-007 ex_stall  input  1  downstream cannot accept a group this cycle.
REQ-008 cand_valid/cand_packet  output  3 / ID_EX_PACKET[2:0]  combinational candidate group driven to hazard detection.
REQ-009 id_stall  output  1  combinational; upstream holds id_valid/id_packet when 1.
REQ-010 issue_valid/issue_packet  output  3 / ID_EX_PACKET[2:0]  registered ID/EX group.
REQ-011 replay_cnt  output  2  registered replay-buffer occupancy (0-3).

Function
REQ-012 Replay buffer SHALL hold 0-3 packets, left-aligned (oldest in slot 0); states PASS (cnt=0), REPLAY (cnt>0).
REQ-013 PASS: cand = id_valid/id_packet; REPLAY: cand = buffer slots, cand_valid[i]=(i<cnt), incoming group ignored.
REQ-014 Way i SHALL issue iff cand_valid[i] and i<3-rollback; held ways = valid ways with i>=3-rollback.
REQ-015 Rollback covering only invalid ways SHALL have no effect; rollback=3 issues nothing.
REQ-016 Normal cycle (no squash, no ex_stall): issue_valid/packet <= issued ways at original way positions, other ways valid=0; buffer <= held ways left-shifted to slot 0; cnt <= held count.
REQ-017 id_stall = ex_stall | (cnt!=0) when squash=0; PASS with held ways SHALL still consume the incoming group (id_stall=0) and capture remainder.
REQ-018 Pipeline latency: cand way issued in cycle N appears on issue_* after edge ending cycle N (1 cycle).
REQ-019 ex_stall=1, squash=0: issue_*, buffer, cnt SHALL hold; id_stall=1; rollback ignored.
REQ-020 squash=1 (priority over ex_stall and rollback): next edge issue_valid<=0, cnt<=0, buffer discarded; id_stall=0 that cycle.
REQ-021 REPLAY with rollback=0 SHALL drain whole buffer in one cycle -> PASS; partial rollback SHALL keep remaining held ways, re-aligned.
REQ-022 Program order SHALL be preserved: no incoming way issues while cnt!=0.

Reset
REQ-023 reset=1 at edge: issue_valid=0, issue_packet=0, cnt=0, state PASS; overrides squash/ex_stall.
REQ-024 During reset cycle id_stall SHALL be 0 and cand reflects incoming group; reset mid-REPLAY discards buffer.

Configuration
REQ-025 Macro ISSUE_HAZARD_CTRL_STATS_EN SHALL add outputs stall_cycles[31:0] and replay_insts[31:0].
REQ-026 With macro: stall_cycles +1 each non-reset cycle id_stall=1; replay_insts += held count each normal cycle; both wrap at 2^32; zero on reset.
REQ-027 Without macro: ports and counters absent; all other behaviour identical.

Verification
REQ-028 PASS, id_valid=111, rollback=0 -> next cycle issue_valid=111, cnt=0, id_stall=0.
REQ-029 PASS, id_valid=111, rollback=2 -> issue_valid=001, cnt=2, buffer slot0=old way1; next cycle id_stall=1, cand_valid=011; rollback=0 -> issue_valid=011, cnt=0.
REQ-030 PASS, id_valid=111, rollback=3 -> issue_valid=000, cnt=3; then rollback=1 -> issue_valid=011, cnt=1; then rollback=0 -> issue_valid=001, cnt=0.
REQ-031 id_valid=001, rollback=1 -> issue_valid=001, cnt=0 (rollback on invalid way ignored).
REQ-032 cnt=2, ex_stall=1 for 3 cycles -> issue_*, cnt unchanged, id_stall=1; then squash=1 with ex_stall=1 -> issue_valid=000, cnt=0, id_stall=0.
REQ-033 cnt=3, reset=1 -> cnt=0, issue_valid=000; with ISSUE_HAZARD_CTRL_STATS_EN, counters read 0 after reset and stall_cycles=2 after two stalled cycles.

Source files
------------

// File: rtl/issue_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : issue_hazard_ctrl
// Brief    : ID/EX issue stage with a 3-entry replay buffer for hazard holds.
//            Optional statistics counters under ISSUE_HAZARD_CTRL_STATS_EN.
// Revision : 1.0
// ============================================================================
module issue_hazard_ctrl #(
    parameter int PACKET_W = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [2:0]               id_valid,
    input  logic [2:0][PACKET_W-1:0] id_packet,
    input  logic [1:0]               rollback,
    input  logic                     squash,
    input  logic                     ex_stall,
    output logic [2:0]               cand_valid,
    output logic [2:0][PACKET_W-1:0] cand_packet,
    output logic                     id_stall,
    output logic [2:0]               issue_valid,
    output logic [2:0][PACKET_W-1:0] issue_packet,
    output logic [1:0]               replay_cnt
`ifdef ISSUE_HAZARD_CTRL_STATS_EN
    ,
    output logic [31:0]              stall_cycles,
    output logic [31:0]              replay_insts
`endif
);

    typedef enum logic [0:0] {
        ST_PASS   = 1'b0,
        ST_REPLAY = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [1:0]                 r_cnt;
    logic [2:0][PACKET_W-1:0]   r_buf;
    logic [2:0]                 r_issue_valid;
    logic [2:0][PACKET_W-1:0]   r_issue_packet;

    logic [1:0]                 w_limit;
    logic [2:0]                 w_issue_mask;
    logic [2:0]                 w_held_mask;
    logic [1:0]                 w_held_cnt;
    logic [2:0][PACKET_W-1:0]   w_held_buf;
    logic                       w_normal;

    assign w_normal = !squash && !ex_stall;
    assign w_limit  = 2'd3 - rollback;

    // Candidate selection; during reset the incoming group is presented directly.
    always_comb begin
        cand_valid  = id_valid;
        cand_packet = id_packet;
        if (!reset && r_state == ST_REPLAY) begin
            cand_packet = r_buf;
            for (int i = 0; i < 3; i++) begin
                cand_valid[i] = (2'(i) < r_cnt);
            end
        end
    end

    // Split candidates into issued and held ways, compacting held ways to slot 0.
    always_comb begin
        w_issue_mask = 3'b000;
        w_held_mask  = 3'b000;
        w_held_cnt   = 2'd0;
        w_held_buf   = '0;
        for (int i = 0; i < 3; i++) begin
            if (cand_valid[i]) begin
                if (2'(i) < w_limit) begin
                    w_issue_mask[i] = 1'b1;
                end else begin
                    w_held_mask[i]         = 1'b1;
                    w_held_buf[w_held_cnt] = cand_packet[i];
                    w_held_cnt             = w_held_cnt + 2'd1;
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (squash) begin
            w_state_next = ST_PASS;
        end else if (!ex_stall) begin
            w_state_next = (w_held_cnt != 2'd0) ? ST_REPLAY : ST_PASS;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= ST_PASS;
            r_cnt          <= 2'd0;
            r_buf          <= '0;
            r_issue_valid  <= 3'b000;
            r_issue_packet <= '0;
        end else begin
            r_state <= w_state_next;
            if (squash) begin
                r_cnt         <= 2'd0;
                r_issue_valid <= 3'b000;
            end else if (!ex_stall) begin
                r_cnt         <= w_held_cnt;
                r_buf         <= w_held_buf;
                r_issue_valid <= w_issue_mask;
                for (int i = 0; i < 3; i++) begin
                    r_issue_packet[i] <= w_issue_mask[i] ? cand_packet[i] : '0;
                end
            end
        end
    end

    assign id_stall     = !reset && !squash && (ex_stall || (r_cnt != 2'd0));
    assign issue_valid  = r_issue_valid;
    assign issue_packet = r_issue_packet;
    assign replay_cnt   = r_cnt;

`ifdef ISSUE_HAZARD_CTRL_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_replay_insts;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cycles <= 32'd0;
            r_replay_insts <= 32'd0;
        end else begin
            if (id_stall) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_normal) begin
                r_replay_insts <= r_replay_insts + {30'd0, w_held_cnt};
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign replay_insts = r_replay_insts;
`else
    logic w_unused;
    assign w_unused = w_normal ^ (^w_held_mask);
`endif

endmodule
`default_nettype wire

// File: tb/tb_issue_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_issue_hazard_ctrl
// Brief    : Directed self-checking bench for issue_hazard_ctrl.
// Revision : 1.0
// ============================================================================
module tb_issue_hazard_ctrl;

    localparam int PW = 16;

    logic                clock = 1'b0;
    logic                reset;
    logic [2:0]          id_valid;
    logic [2:0][PW-1:0]  id_packet;
    logic [1:0]          rollback;
    logic                squash;
    logic                ex_stall;
    logic [2:0]          cand_valid;
    logic [2:0][PW-1:0]  cand_packet;
    logic                id_stall;
    logic [2:0]          issue_valid;
    logic [2:0][PW-1:0]  issue_packet;
    logic [1:0]          replay_cnt;
`ifdef ISSUE_HAZARD_CTRL_STATS_EN
    logic [31:0]         stall_cycles;
    logic [31:0]         replay_insts;
`endif

    int checks = 0;
    int errors = 0;

    issue_hazard_ctrl #(.PACKET_W(PW)) dut (
        .clock        (clock),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_packet    (id_packet),
        .rollback     (rollback),
        .squash       (squash),
        .ex_stall     (ex_stall),
        .cand_valid   (cand_valid),
        .cand_packet  (cand_packet),
        .id_stall     (id_stall),
        .issue_valid  (issue_valid),
        .issue_packet (issue_packet),
        .replay_cnt   (replay_cnt)
`ifdef ISSUE_HAZARD_CTRL_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .replay_insts (replay_insts)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [2:0][PW-1:0] grp(input logic [PW-1:0] base);
        grp[0] = base;
        grp[1] = base + 16'd1;
        grp[2] = base + 16'd2;
    endfunction

    initial begin
        reset = 1'b1; id_valid = 3'b111; id_packet = grp(16'hA000);
        rollback = 2'd0; squash = 1'b0; ex_stall = 1'b0;
        #1;
        chk("rst_id_stall", 64'(id_stall), 64'd0);
        chk("rst_cand_valid", 64'(cand_valid), 64'h7);
        step();
        chk("rst_issue_valid", 64'(issue_valid), 64'd0);
        chk("rst_issue_packet", 64'(issue_packet), 64'd0);
        chk("rst_cnt", 64'(replay_cnt), 64'd0);

        // Full group, no hazard
        reset = 1'b0;
        #1;
        chk("pass_cand", 64'(cand_packet), 64'(grp(16'hA000)));
        chk("pass_id_stall", 64'(id_stall), 64'd0);
        step();
        chk("full_issue_valid", 64'(issue_valid), 64'h7);
        chk("full_issue_packet", 64'(issue_packet), 64'h0000_A002_A001_A000);
        chk("full_cnt", 64'(replay_cnt), 64'd0);

        // Rollback 2 then drain
        id_packet = grp(16'hB000); rollback = 2'd2;
        step();
        chk("rb2_issue_valid", 64'(issue_valid), 64'h1);
        chk("rb2_issue_pkt0", 64'(issue_packet[0]), 64'hB000);
        chk("rb2_cnt", 64'(replay_cnt), 64'd2);
        id_packet = grp(16'hC000); rollback = 2'd0;
        #1;
        chk("rb2_id_stall", 64'(id_stall), 64'd1);
        chk("rb2_cand_valid", 64'(cand_valid), 64'h3);
        chk("rb2_cand_pkt", 64'({cand_packet[1], cand_packet[0]}), 64'hB002_B001);
        step();
        chk("drain_issue_valid", 64'(issue_valid), 64'h3);
        chk("drain_issue_pkt", 64'({issue_packet[1], issue_packet[0]}), 64'hB002_B001);
        chk("drain_cnt", 64'(replay_cnt), 64'd0);
        #1;
        chk("drain_id_stall", 64'(id_stall), 64'd0);
        chk("drain_cand", 64'(cand_packet), 64'(grp(16'hC000)));

        // Rollback 3, then 1, then 0
        rollback = 2'd3;
        step();
        chk("rb3_issue_valid", 64'(issue_valid), 64'h0);
        chk("rb3_cnt", 64'(replay_cnt), 64'd3);
        id_packet = grp(16'hD000); rollback = 2'd1;
        #1;
        chk("rb3_cand_valid", 64'(cand_valid), 64'h7);
        chk("rb3_cand_pkt", 64'(cand_packet), 64'(grp(16'hC000)));
        step();
        chk("rb1_issue_valid", 64'(issue_valid), 64'h3);
        chk("rb1_issue_pkt", 64'({issue_packet[1], issue_packet[0]}), 64'hC001_C000);
        chk("rb1_cnt", 64'(replay_cnt), 64'd1);
        rollback = 2'd0;
        #1;
        chk("rb1_cand_valid", 64'(cand_valid), 64'h1);
        chk("rb1_cand_pkt0", 64'(cand_packet[0]), 64'hC002);
        step();
        chk("rb0_issue_valid", 64'(issue_valid), 64'h1);
        chk("rb0_issue_pkt0", 64'(issue_packet[0]), 64'hC002);
        chk("rb0_cnt", 64'(replay_cnt), 64'd0);

        // Rollback covering only an invalid way
        id_valid = 3'b001; rollback = 2'd1;
        step();
        chk("inv_issue_valid", 64'(issue_valid), 64'h1);
        chk("inv_issue_pkt0", 64'(issue_packet[0]), 64'hD000);
        chk("inv_cnt", 64'(replay_cnt), 64'd0);

        // Sparse group: held way 2 must move to slot 0
        id_valid = 3'b101; id_packet = grp(16'hE000); rollback = 2'd2;
        step();
        chk("sparse_issue_valid", 64'(issue_valid), 64'h1);
        chk("sparse_cnt", 64'(replay_cnt), 64'd1);
        rollback = 2'd0;
        #1;
        chk("sparse_cand_valid", 64'(cand_valid), 64'h1);
        chk("sparse_cand_pkt0", 64'(cand_packet[0]), 64'hE002);
        step();
        chk("sparse_drain_valid", 64'(issue_valid), 64'h1);
        chk("sparse_drain_pkt0", 64'(issue_packet[0]), 64'hE002);

        // cnt=2 then ex_stall for 3 cycles, then squash
        id_valid = 3'b111; id_packet = grp(16'hF000); rollback = 2'd2;
        step();
        chk("f_cnt", 64'(replay_cnt), 64'd2);
        ex_stall = 1'b1; rollback = 2'd3;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_id_stall", 64'(id_stall), 64'd1);
            step();
            chk("stall_issue_valid", 64'(issue_valid), 64'h1);
            chk("stall_issue_pkt0", 64'(issue_packet[0]), 64'hF000);
            chk("stall_cnt", 64'(replay_cnt), 64'd2);
        end
        squash = 1'b1;
        #1;
        chk("squash_id_stall", 64'(id_stall), 64'd0);
        step();
        chk("squash_issue_valid", 64'(issue_valid), 64'h0);
        chk("squash_cnt", 64'(replay_cnt), 64'd0);
        squash = 1'b0; ex_stall = 1'b0; rollback = 2'd0; id_packet = grp(16'h1000);
        #1;
        chk("post_squash_cand", 64'(cand_packet), 64'(grp(16'h1000)));
        step();
        chk("post_squash_issue", 64'(issue_valid), 64'h7);
`ifdef ISSUE_HAZARD_CTRL_STATS_EN
        chk("stats_stall", 64'(stall_cycles), 64'd7);
        chk("stats_replay", 64'(replay_insts), 64'd9);
`endif

        // Reset in the middle of REPLAY
        id_packet = grp(16'h2000); rollback = 2'd3;
        step();
        chk("pre_rst_cnt", 64'(replay_cnt), 64'd3);
        reset = 1'b1; id_valid = 3'b010; rollback = 2'd0;
        #1;
        chk("mid_rst_id_stall", 64'(id_stall), 64'd0);
        chk("mid_rst_cand_valid", 64'(cand_valid), 64'h2);
        step();
        chk("mid_rst_cnt", 64'(replay_cnt), 64'd0);
        chk("mid_rst_issue_valid", 64'(issue_valid), 64'h0);
`ifdef ISSUE_HAZARD_CTRL_STATS_EN
        chk("rst_stats_stall", 64'(stall_cycles), 64'd0);
        chk("rst_stats_replay", 64'(replay_insts), 64'd0);
`endif
        reset = 1'b0; ex_stall = 1'b1;
        step();
        step();
        chk("rst_stall_issue_valid", 64'(issue_valid), 64'h0);
`ifdef ISSUE_HAZARD_CTRL_STATS_EN
        chk("stats_two_stalls", 64'(stall_cycles), 64'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
